// File: rtl/rv_mem_pkg.sv
// Shared memory-bus definitions: FSM state encoding, lane-offset helper and
// the request record used by the core LSU.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_RESP
    } mem_state_t;

    // Number of byte-offset bits inside one bus word (0 for a byte-wide bus).
    function automatic int lane_off_w(input int be_w);
        return (be_w > 1) ? $clog2(be_w) : 0;
    endfunction

    localparam int CORE_DATA_W     = 32;
    localparam int CORE_ADDR_W     = 32;
    localparam int CORE_BE_W       = CORE_DATA_W / 8;
    localparam int CORE_LANE_OFF_W = lane_off_w(CORE_BE_W);

    // One bus request as produced by the core LSU.
    typedef struct packed {
        logic                   we;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_BE_W-1:0]   be;
        logic [CORE_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/bus_ram_if.sv
// Valid/ready request/response bus between the core and a memory target.
interface bus_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    import rv_mem_pkg::*;

    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/bus_ram_array.sv
// Byte-lane storage array: per-lane write enables, registered read port.
module bus_ram_array
    import rv_mem_pkg::*;
#(
    parameter int BE_W  = 4,
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic                    re,
    input  logic [AW-1:0]           addr,
    input  logic [BE_W-1:0]         be,
    input  logic [BE_W-1:0][7:0]    wdata,
    output logic [BE_W-1:0][7:0]    rdata
);

    logic [BE_W-1:0][7:0] mem [WORDS];

    // Lane-masked write and registered read; the read returns the word as it was before this edge.
    // NOTE: storage has no reset -- clearing a RAM needs a per-word sequencer and blocks RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][i] <= wdata[i];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_ram.sv
// Byte-addressable little-endian RAM target with valid/ready handshake,
// configurable read latency and misaligned/out-of-range error reporting.
module bus_ram
    import rv_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int RD_LAT      = 1
) (
    input  logic      clk,
    input  logic      rst,
    bus_ram_if.slave  bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = lane_off_w(BE_W);
    localparam int WORDS = DEPTH_BYTES / BE_W;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // WAIT holds for RD_LAT-1 cycles; the counter is loaded so that it hits zero on the last one.
    localparam logic [1:0] LAT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    mem_state_t         state;
    logic [1:0]         lat_cnt;
    logic               err_q;
    logic               rd_q;
    logic [BE_W-1:0]    be_q;

    logic               accept;
    logic               addr_err;
    logic [AW-1:0]      word_addr;
    logic               arr_we;
    logic               arr_re;
    logic [BE_W-1:0][7:0] arr_rdata;
    logic [BE_W-1:0][7:0] masked_rdata;

    // Request qualification and address check.
    assign accept    = bus.req_valid && bus.req_ready;
    assign addr_err  = ((bus.req_addr & ADDR_W'(BE_W - 1)) != '0) ||
                       (bus.req_addr > ADDR_W'(DEPTH_BYTES - BE_W));
    assign word_addr = AW'(bus.req_addr >> OFF_W);
    assign arr_we    = accept &&  bus.req_we && !addr_err;
    assign arr_re    = accept && !bus.req_we && !addr_err;

    bus_ram_array #(
        .BE_W  (BE_W),
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (word_addr),
        .be    (bus.req_be),
        .wdata (bus.req_wdata),
        .rdata (arr_rdata)
    );

    // Transaction FSM: accept in IDLE, optional latency wait, hold response until consumed.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MS_IDLE;
            lat_cnt <= 2'd0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            be_q    <= '0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (accept) begin
                        err_q <= addr_err;
                        rd_q  <= !bus.req_we && !addr_err;
                        be_q  <= bus.req_be;
                        if (!bus.req_we && !addr_err && RD_LAT > 1) begin
                            state   <= MS_WAIT;
                            lat_cnt <= LAT_LOAD;
                        end else begin
                            state <= MS_RESP;
                        end
                    end
                end
                MS_WAIT: begin
                    if (lat_cnt == 2'd0) state <= MS_RESP;
                    else                 lat_cnt <= lat_cnt - 2'd1;
                end
                MS_RESP: begin
                    if (bus.rsp_ready) state <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

    // Zero the lanes that were not enabled on the read.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        masked_rdata = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (be_q[i]) masked_rdata[i] = arr_rdata[i];
        end
    end

    assign bus.req_ready = !rst && (state == MS_IDLE);
    assign bus.rsp_valid = (state == MS_RESP);
    assign bus.rsp_err   = (state == MS_RESP) && err_q;
    assign bus.rsp_rdata = ((state == MS_RESP) && rd_q) ? masked_rdata : '0;

endmodule
